spi_xfer_sequencer: RTL and testbench
=====================================

// Module: spi_xfer_sequencer
// PURPOSE
//  Sequences one SPI flash transaction on the SPI shift/latch datapath. Accepts a
//  request, then pulses setup_rst and loadtxdata_en. Drives ss_n and sclk from a
//  programmable divider. Emits one-cycle latchout_en/latchin_en strobes on the
//  shift/sample edges. Signals done when ss_n deasserts.
//  Sits between the SPI register interface (requester) and the shift/latch datapath.
// PARAMETERS
//  DIV_W   8   width of clk_div (SCLK half-period in clk cycles)
//  CNT_W   9   width of num_cycles (SCLK cycles per transaction)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous, active-high reset
//  req_valid   in   1      transaction request
//  req_ready   out  1      high only in IDLE; transfer on valid&ready
//  clk_div     in   DIV_W  SCLK half-period in clk cycles; 0 treated as 1; sampled at accept
//  cpol        in   1      SCLK idle level; sampled at accept
//  num_cycles  in   CNT_W  SCLK cycles (cmd+addr+dummy+data); sampled at accept
//  abort       in   1      synchronous abort, any state
//  sclk        out  1      SPI clock
//  ss_n        out  1      chip select, active low
//  sclk_en     out  1      high throughout RUN
//  latchout_en out  1      1-cycle strobe: drive next tx bit(s)
//  latchin_en  out  1      1-cycle strobe: sample rx bit(s)
//  setup_rst   out  1      1-cycle pulse: clear datapath counters
//  loadtxdata_en out 1     1-cycle pulse: load tx string (same cycle as setup_rst)
//  busy        out  1      high in every state except IDLE
//  done        out  1      1-cycle pulse on completion or abort
// BEHAVIOUR
//  Reset values: sclk=0, ss_n=1, req_ready=1, all strobes, busy and done = 0.
//  State=IDLE. Registered config = 0. The registered cpol resets to 0, so sclk resets to 0.
//  FSM: IDLE -> SETUP -> CSLEAD -> RUN -> CSHOLD -> IDLE.
//  - IDLE: sclk=cpol_r, ss_n=1. Accept on req_valid; latch clk_div/cpol/num_cycles.
//  - SETUP (1 cyc): setup_rst=loadtxdata_en=1; ss_n=1.
//  - CSLEAD: ss_n=0; stays for div cycles (div = max(clk_div,1)).
//    If num_cycles==0, goes to CSHOLD instead of RUN.
//  - RUN: divider div_cnt counts 0..div-1; tick when div_cnt==div-1; sclk toggles on tick.
//    latchout_en=1 in the first RUN cycle (first bit). It is also 1 in the cycle after
//    each trailing-edge tick, except the last.
//    latchin_en=1 in the cycle after each leading-edge tick.
//    edge_cnt counts leading edges. RUN exits after the trailing edge following
//    leading edge number num_cycles, with sclk back at cpol_r.
//  - CSHOLD: ss_n=0 for div cycles, then ss_n=1. done pulses in the first IDLE cycle.
//  SCLK period = 2*div clk cycles. Strobe counts per transaction:
//  exactly num_cycles latchin_en and num_cycles latchout_en.
//  The leading edge is rising if cpol=0, falling if cpol=1 (CPHA=0 only).
//  latchin_en and latchout_en are never high in the same cycle.
//  abort: from any non-IDLE state, the next cycle goes to IDLE with sclk=cpol_r, ss_n=1,
//  strobes=0, and a done pulse. abort in IDLE is ignored. abort beats req_valid.
//  Back-to-back requests: req_ready rises in the done cycle. A request accepted that
//  cycle enters SETUP the next cycle, so ss_n is high for at least 2 cycles between
//  transactions.
//  Counters are CNT_W wide and do not wrap: num_cycles = 2^CNT_W-1 is legal.
//  rst mid-transaction returns to IDLE immediately (async); no done pulse.
// TESTING
//  1) clk_div=2, cpol=0, num_cycles=8 -> setup_rst/loadtxdata_en same single cycle;
//     8 sclk periods of 4 clk each; 8 latchin_en and 8 latchout_en; one done pulse.
//  2) clk_div=0 vs 1, num_cycles=3 -> identical waveforms, sclk period 2 clk.
//  3) cpol=1, clk_div=3, num_cycles=4 -> sclk idles 1; latchin_en follows falling edges;
//     sclk=1 when ss_n rises.
//  4) num_cycles=0 -> ss_n low for 2*div cycles, no sclk edges, no latch strobes, done=1.
//  5) abort in RUN after the 5th leading edge of 32 -> next cycle ss_n=1, sclk=cpol,
//     done pulse; a following request runs all 32 cycles normally.
//  6) req_valid held high -> two transactions back-to-back, ss_n high >=2 cycles
//     between them; rst asserted mid-RUN -> all outputs at reset values, no done.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
// Sequences one SPI flash transaction for the shift/latch datapath. It accepts a
// request and pulses the datapath setup strobes. It then drives ss_n and sclk from
// a programmable half-period divider, and emits one-cycle latch strobes on the
// shift and sample edges. A done pulse marks completion or abort.
module spi_xfer_sequencer #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cpol,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             abort,
  output logic             sclk,
  output logic             ss_n,
  output logic             sclk_en,
  output logic             latchout_en,
  output logic             latchin_en,
  output logic             setup_rst,
  output logic             loadtxdata_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_CSLEAD = 3'd2,
    S_RUN    = 3'd3,
    S_CSHOLD = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  // Configuration captured when a request is accepted. div_r is never zero,
  // because a requested divide of 0 runs as a divide of 1.
  logic [DIV_W-1:0] div_r;
  logic             cpol_r;
  logic [CNT_W-1:0] ncyc_r;

  // The half-period divider, shared by the CSLEAD, RUN and CSHOLD timing.
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;
  logic             tick;
  logic             timed_state;

  // SCLK phase: 0 = idle level (cpol_r), 1 = after the leading edge. sclk is
  // cpol_r ^ phase. The phase only leaves 0 in RUN, so sclk rests at cpol_r
  // everywhere else.
  logic             phase;
  logic [CNT_W-1:0] edge_cnt;
  logic             last_edge;

  // Registered strobes. Each one is raised one cycle after the edge it tracks.
  logic             first_run;
  logic             lin_q;
  logic             lout_q;
  logic             done_q;

  logic             accept;

  assign div_last    = div_r - DIV_W'(1);
  assign tick        = (div_cnt == div_last);
  assign timed_state = (state == S_CSLEAD) || (state == S_RUN) || (state == S_CSHOLD);
  assign last_edge   = (edge_cnt == ncyc_r);
  assign accept      = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: all clocked state uses non-blocking assignments. Every register then
      // samples pre-edge values, whatever order the simulator runs the blocks in.
      state <= state_nx;
    end
  end

  // Next-state logic. An abort outside IDLE overrides every other transition.
  always_comb begin
    // NOTE: the default assignment comes first, so every path assigns state_nx.
    // Without it, a missing branch would infer a latch.
    state_nx = state;
    if ((state != S_IDLE) && abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (accept) state_nx = S_SETUP;
        S_SETUP:  state_nx = S_CSLEAD;
        S_CSLEAD: if (tick) state_nx = (ncyc_r == '0) ? S_CSHOLD : S_RUN;
        S_RUN:    if (tick && phase && last_edge) state_nx = S_CSHOLD;
        S_CSHOLD: if (tick) state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Capture the transaction configuration at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r  <= '0;
      cpol_r <= 1'b0;
      ncyc_r <= '0;
    end else if (accept) begin
      div_r  <= (clk_div == '0) ? DIV_W'(1) : clk_div;
      cpol_r <= cpol;
      ncyc_r <= num_cycles;
    end
  end

  // Half-period divider. It restarts at every state change, so each timed
  // state begins with a full div-cycle interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!timed_state || (state_nx != state) || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // SCLK phase and leading-edge count. Both clear as soon as RUN is left or
  // aborted, which returns sclk to its idle level on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 1'b0;
      edge_cnt <= '0;
    end else if ((state == S_RUN) && !abort) begin
      if (tick) begin
        phase <= ~phase;
        if (!phase) begin
          edge_cnt <= edge_cnt + CNT_W'(1);
        end
      end
    end else begin
      phase    <= 1'b0;
      edge_cnt <= '0;
    end
  end

  // One-cycle strobes, raised in the cycle after the event that causes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_run <= 1'b0;
      lin_q     <= 1'b0;
      lout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Entering RUN presents the first tx bit.
      first_run <= (state == S_CSLEAD) && (state_nx == S_RUN);
      // A leading edge samples rx. That edge is never the last cycle of RUN.
      lin_q     <= (state == S_RUN) && !abort && tick && !phase;
      // Each trailing edge shifts the next tx bit, except the final one.
      lout_q    <= (state == S_RUN) && !abort && tick && phase && !last_edge;
      // Completion and abort both return to IDLE. done marks that first IDLE cycle.
      done_q    <= (state != S_IDLE) && (state_nx == S_IDLE);
    end
  end

  // Output decode from the state and registered timing.
  always_comb begin
    req_ready     = (state == S_IDLE) && !abort;
    busy          = (state != S_IDLE);
    setup_rst     = (state == S_SETUP);
    loadtxdata_en = (state == S_SETUP);
    ss_n          = !timed_state;
    sclk_en       = (state == S_RUN);
    sclk          = cpol_r ^ phase;
    latchin_en    = lin_q;
    latchout_en   = first_run || lout_q;
    done          = done_q;
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer. The driver issues requests and, at
// each accept, queues the hand-derived event timeline (setup, ss_n/sclk edges,
// latch strobes, done). A monitor turns DUT activity into events and compares
// them in order against that queue.
module tb_spi_xfer_sequencer;
  localparam int DIV_W = 8;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [DIV_W-1:0] clk_div = '0;
  logic             cpol = 1'b0;
  logic [CNT_W-1:0] num_cycles = '0;
  logic             abort = 1'b0;
  logic             sclk, ss_n, sclk_en, latchout_en, latchin_en;
  logic             setup_rst, loadtxdata_en, busy, done;

  spi_xfer_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .clk_div(clk_div), .cpol(cpol), .num_cycles(num_cycles), .abort(abort),
    .sclk(sclk), .ss_n(ss_n), .sclk_en(sclk_en), .latchout_en(latchout_en),
    .latchin_en(latchin_en), .setup_rst(setup_rst), .loadtxdata_en(loadtxdata_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum logic [3:0] {
    EV_SETUP = 4'd1, EV_SS = 4'd2, EV_SCLK = 4'd3,
    EV_LOUT = 4'd4, EV_LIN = 4'd5, EV_DONE = 4'd6, EV_BAD = 4'd7
  } ev_kind_t;

  // Hex-readable event: kind | cycle | sclk | ss_n | {busy, sclk_en}
  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] cyc;
    logic [3:0]  sclk;
    logic [3:0]  ss_n;
    logic [3:0]  st;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  last_cp  = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic ev_t mk(input ev_kind_t k, input int c, input logic s,
                             input logic ss, input logic [1:0] st);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.sclk = {3'b000, s};
    e.ss_n = {3'b000, ss};
    e.st   = {2'b00, st};
    return e;
  endfunction

  // Expected timeline for a request accepted in cycle a, with d = max(dv,1):
  //   a+1 SETUP, a+2 ss_n falls, run starts r = a+2+d;
  //   bit k: LOUT at r+2dk, leading edge + LIN at r+d+2dk, trailing edge at r+2d(k+1);
  //   D = r+2dn+d: ss_n rises and done.
  // stop_lin>0 cuts the run after that LIN: an abort then ends it on the next
  // cycle, and a reset ends it with no further events.
  task automatic push_txn(input int a, input int dv, input bit cp, input int n,
                          input int stop_lin, input bit aborted, output int stop_cyc);
    int d, r, x;
    d = (dv == 0) ? 1 : dv;
    r = a + 2 + d;
    stop_cyc = -1;
    exp_q.push_back(mk(EV_SETUP, a + 1, cp, 1'b1, 2'b10));
    if (cp != last_cp) exp_q.push_back(mk(EV_SCLK, a + 1, cp, 1'b1, 2'b10));
    last_cp = cp;
    exp_q.push_back(mk(EV_SS, a + 2, cp, 1'b0, 2'b10));
    for (int k = 0; k < n; k++) begin
      if (k > 0) exp_q.push_back(mk(EV_SCLK, r + 2*d*k, cp, 1'b0, 2'b11));
      exp_q.push_back(mk(EV_LOUT, r + 2*d*k, cp, 1'b0, 2'b11));
      exp_q.push_back(mk(EV_SCLK, r + d + 2*d*k, !cp, 1'b0, 2'b11));
      exp_q.push_back(mk(EV_LIN, r + d + 2*d*k, !cp, 1'b0, 2'b11));
      if (stop_lin == k + 1) begin
        x = r + d + 2*d*k;
        stop_cyc = x;
        if (aborted) begin
          exp_q.push_back(mk(EV_SS, x + 1, cp, 1'b1, 2'b00));
          exp_q.push_back(mk(EV_SCLK, x + 1, cp, 1'b1, 2'b00));
          exp_q.push_back(mk(EV_DONE, x + 1, cp, 1'b1, 2'b00));
        end else begin
          last_cp = 1'b0;
        end
        return;
      end
    end
    if (n > 0) exp_q.push_back(mk(EV_SCLK, r + 2*d*n, cp, 1'b0, 2'b10));
    exp_q.push_back(mk(EV_SS, r + 2*d*n + d, cp, 1'b1, 2'b00));
    exp_q.push_back(mk(EV_DONE, r + 2*d*n + d, cp, 1'b1, 2'b00));
  endtask

  task automatic observe(input ev_kind_t k);
    ev_t got, exp;
    got = mk(k, cyc, sclk, ss_n, {busy, sclk_en});
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got %0h expected none", got);
    end else begin
      exp = exp_q.pop_front();
      check($sformatf("event@%0d", cyc), 64'(got), 64'(exp));
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic prev_sclk, prev_ss;
    prev_sclk = 1'b0;
    prev_ss   = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_sclk = sclk;
        prev_ss   = ss_n;
        continue;
      end
      if (setup_rst || loadtxdata_en) observe((setup_rst && loadtxdata_en) ? EV_SETUP : EV_BAD);
      if (ss_n != prev_ss) observe(EV_SS);
      if (sclk != prev_sclk) observe(EV_SCLK);
      if (latchout_en && latchin_en) begin
        observe(EV_BAD);
      end else begin
        if (latchout_en) observe(EV_LOUT);
        if (latchin_en) observe(EV_LIN);
      end
      if (done) observe(EV_DONE);
      prev_sclk = sclk;
      prev_ss   = ss_n;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, sclk, 1'b0);
    check({tag, "_ss_n"}, ss_n, 1'b1);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_strobes"}, {sclk_en, latchout_en, latchin_en, setup_rst, loadtxdata_en}, 5'b0);
  endtask

  // Issue a request. keep leaves req_valid high for a back-to-back follow-on.
  // stop_lin>0 ends the run after that LIN, by abort (use_abort) or by reset.
  task automatic issue(input int dv, input bit cp, input int n, input int stop_lin,
                       input bit use_abort, input bit keep);
    int a, x, waited;
    @(negedge clk);
    clk_div    = DIV_W'(dv);
    cpol       = cp;
    num_cycles = CNT_W'(n);
    req_valid  = 1'b1;
    waited     = 0;
    #1;
    while (!req_ready) begin
      if (waited > 3000) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: got req_ready=0 required 1 within 3000 cycles");
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
      waited++;
    end
    a = cyc;
    push_txn(a, dv, cp, n, stop_lin, use_abort, x);
    if (!keep) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    if (stop_lin > 0) begin
      while (cyc < x) @(negedge clk);
      if (use_abort) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end else begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_rst");
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    #22;
    check_reset_outputs("reset");
    @(negedge clk);
    #1;
    rst = 1'b0;

    issue(2, 1'b0, 8, 0, 1'b0, 1'b0);   // baseline: div 2, cpol 0, 8 bits
    issue(0, 1'b0, 3, 0, 1'b0, 1'b0);   // divide 0 runs as divide 1
    issue(1, 1'b0, 3, 0, 1'b0, 1'b0);   // ... with the same timeline
    issue(3, 1'b1, 4, 0, 1'b0, 1'b0);   // cpol 1: leading edge falls
    issue(2, 1'b0, 0, 0, 1'b0, 1'b0);   // zero-length: ss_n only, no sclk
    issue(1, 1'b0, 32, 5, 1'b1, 1'b0);  // abort after the 5th leading edge
    issue(1, 1'b0, 32, 0, 1'b0, 1'b0);  // full 32-bit run after abort
    issue(2, 1'b0, 2, 0, 1'b0, 1'b1);   // back-to-back, req_valid held
    issue(1, 1'b1, 3, 0, 1'b0, 1'b0);
    issue(1, 1'b0, 8, 3, 1'b0, 1'b0);   // reset during RUN: no done
    issue(4, 1'b0, 2, 0, 1'b0, 1'b0);   // normal operation after reset

    waited = 0;
    while (exp_q.size() != 0 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    repeat (10) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
